// File: rtl/smi_self_link_fifo.sv
// Multi-entry SMI SELF link FIFO: registered output head plus a circular buffer.
// Every control output is a flop computed from next-state, so valid/stop never cut through.
module smi_self_link_fifo #(
  parameter int DataWidth       = 16,
  parameter int FifoDepth       = 4,
  parameter int AlmostFullLevel = 3
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic [DataWidth-1:0]               dataIn,
  input  logic                               dataInValid,
  output logic                               dataInStop,
  output logic [DataWidth-1:0]               dataOut,
  output logic                               dataOutValid,
  input  logic                               dataOutStop,
  output logic [$clog2(FifoDepth+1)-1:0]     fillLevel,
  output logic                               almostFull
);

  localparam int CntW     = $clog2(FifoDepth+1);
  localparam int BufDepth = FifoDepth - 1;
  localparam int PtrW     = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);
  localparam logic [CntW-1:0] AfCnt   = CntW'(AlmostFullLevel);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(BufDepth - 1);

  logic [DataWidth-1:0] bufMem [BufDepth];
  logic [PtrW-1:0]      rdPtr, wrPtr;
  logic [CntW-1:0]      count, countNext;
  logic push, pop, bufEmpty, loadDirect, loadFromBuf, bufWrite, updEn;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign push        = dataInValid & ~dataInStop;
  assign pop         = dataOutValid & ~dataOutStop;
  assign bufEmpty    = (count <= CntW'(1));
  // Bypass the buffer whenever the head slot is (or is becoming) free and nothing waits behind it.
  assign loadDirect  = push & (~dataOutValid | (pop & bufEmpty));
  assign loadFromBuf = pop & ~bufEmpty;
  assign bufWrite    = push & ~loadDirect;
  assign countNext   = count + CntW'(push) - CntW'(pop);
  // The extra term lets stop drop once after reset with no traffic.
  assign updEn       = push | pop | (dataInStop & (count != FullCnt));

  always_ff @(posedge clk) begin
    if (srst) begin
      count        <= '0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      dataOutValid <= 1'b0;
      almostFull   <= 1'b0;
      dataInStop   <= 1'b1;
    end else if (updEn) begin
      count        <= countNext;
      dataOutValid <= (countNext != '0);
      almostFull   <= (countNext >= AfCnt);
      dataInStop   <= (countNext == FullCnt);
      if (loadFromBuf) rdPtr <= incPtr(rdPtr);
      if (bufWrite)    wrPtr <= incPtr(wrPtr);
    end
  end

  always_ff @(posedge clk) begin
    if (loadDirect)       dataOut <= dataIn;
    else if (loadFromBuf) dataOut <= bufMem[rdPtr];
    if (bufWrite) bufMem[wrPtr] <= dataIn;
  end

  assign fillLevel = count;

endmodule

// File: tb/tb_smi_self_link_fifo.sv
// Directed table plus multi-depth random stress for smi_self_link_fifo.
module tb_smi_self_link_fifo;

  logic        clk = 1'b0;
  logic        srst;
  logic [15:0] dataIn;
  logic        dataInValid, dataInStop;
  logic [15:0] dataOut;
  logic        dataOutValid, dataOutStop;
  logic [2:0]  fillLevel;
  logic        almostFull;

  int nChk = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  smi_self_link_fifo #(.DataWidth(16), .FifoDepth(4), .AlmostFullLevel(3)) dut (
    .clk(clk), .srst(srst), .dataIn(dataIn), .dataInValid(dataInValid),
    .dataInStop(dataInStop), .dataOut(dataOut), .dataOutValid(dataOutValid),
    .dataOutStop(dataOutStop), .fillLevel(fillLevel), .almostFull(almostFull));

  // stress instances share random stimulus, each checked against its own model
  logic        sRst, sValid, sStop;
  logic [15:0] sData;
  logic [3:0]  sInStopA, sOutValidA, sAfA;
  logic [15:0] sOutA [4];
  int          sFillA [4];

  function automatic int depthOf(input int g);
    return (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 7;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gS
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 7;
    localparam int CW = $clog2(D+1);
    logic [CW-1:0] f;
    logic [15:0]   o;
    logic          st, ov, af;
    smi_self_link_fifo #(.DataWidth(16), .FifoDepth(D), .AlmostFullLevel(D-1)) u (
      .clk(clk), .srst(sRst), .dataIn(sData), .dataInValid(sValid),
      .dataInStop(st), .dataOut(o), .dataOutValid(ov),
      .dataOutStop(sStop), .fillLevel(f), .almostFull(af));
    assign sInStopA[g]   = st;
    assign sOutValidA[g] = ov;
    assign sAfA[g]       = af;
    assign sOutA[g]      = o;
    assign sFillA[g]     = int'(f);
  end

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        os;
    logic        eV;
    logic [15:0] eD;
    int          eFill;
    logic        eStop;
    logic        eAf;
  } vec_t;

  vec_t tbl [11];
  int   mHead [4];
  int   mCnt  [4];
  logic [15:0] mBuf [4][64];

  task automatic chk(input string nm, input int act, input int exp);
    nChk++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkState(input string nm, input int v, input int fill, input int st, input int af);
    chk({nm, ".valid"}, int'(dataOutValid), v);
    chk({nm, ".fill"},  int'(fillLevel), fill);
    chk({nm, ".stop"},  int'(dataInStop), st);
    chk({nm, ".af"},    int'(almostFull), af);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h000A, 1'b1, 1'b1, 16'h000A, 1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h000B, 1'b1, 1'b1, 16'h000A, 2, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h000C, 1'b1, 1'b1, 16'h000A, 3, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 16'h000D, 1'b1, 1'b1, 16'h000A, 4, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 16'h000E, 1'b1, 1'b1, 16'h000A, 4, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 16'h000E, 1'b0, 1'b1, 16'h000B, 3, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 16'h000E, 1'b0, 1'b1, 16'h000C, 3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h000D, 2, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h000E, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};

    srst = 1'b1; dataIn = '0; dataInValid = 1'b0; dataOutStop = 1'b0;
    sRst = 1'b1; sValid = 1'b0; sStop = 1'b0; sData = '0;

    // reset and release handshake
    for (int i = 0; i < 3; i++) begin
      step();
      chkState("rst", 0, 0, 1, 0);
    end
    srst = 1'b0;
    dataInValid = 1'b1; dataIn = 16'hDEAD;
    #1 chk("rel.stop1", int'(dataInStop), 1);
    step();
    chkState("rel.after", 0, 0, 0, 0);

    // single token
    dataIn = 16'h1234;
    step();
    chkState("single", 1, 1, 0, 0);
    chk("single.data", int'(dataOut), 'h1234);
    dataInValid = 1'b0;
    step();
    chkState("single.pop", 0, 0, 0, 0);

    // streaming 0..31 at full rate
    for (int i = 0; i < 32; i++) begin
      dataInValid = 1'b1; dataIn = 16'(i);
      step();
      chk("stream.data", int'(dataOut), i);
      chkState("stream", 1, 1, 0, 0);
    end
    dataInValid = 1'b0;
    step();
    chkState("stream.end", 0, 0, 0, 0);

    // fill to full, hold E upstream, drain in order
    for (int r = 0; r < 11; r++) begin
      dataInValid = tbl[r].v; dataIn = tbl[r].d; dataOutStop = tbl[r].os;
      step();
      chkState($sformatf("tbl%0d", r), int'(tbl[r].eV), tbl[r].eFill, int'(tbl[r].eStop), int'(tbl[r].eAf));
      if (tbl[r].eV) chk($sformatf("tbl%0d.data", r), int'(dataOut), int'(tbl[r].eD));
    end

    // reset with three tokens held
    dataOutStop = 1'b1; dataInValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      dataIn = 16'(i * 'h11);
      step();
    end
    chkState("mid.pre", 1, 3, 0, 1);
    dataInValid = 1'b0; srst = 1'b1;
    step();
    chkState("mid.rst", 0, 0, 1, 0);
    srst = 1'b0; dataOutStop = 1'b0; dataInValid = 1'b1; dataIn = 16'h0055;
    #1 chk("mid.rel.stop", int'(dataInStop), 1);
    step();
    chkState("mid.rel", 0, 0, 0, 0);
    dataIn = 16'h0077;
    step();
    chkState("mid.push", 1, 1, 0, 0);
    chk("mid.data", int'(dataOut), 'h77);
    dataInValid = 1'b0;
    step();
    chkState("mid.drain", 0, 0, 0, 0);

    // random stress over depths 2,3,4,7
    step(); step();
    sRst = 1'b0;
    step();
    for (int g = 0; g < 4; g++) begin mHead[g] = 0; mCnt[g] = 0; end
    for (int c = 0; c < 1000; c++) begin
      sValid = 1'($urandom_range(0, 1));
      sStop  = 1'($urandom_range(0, 1));
      sData  = 16'($urandom);
      for (int g = 0; g < 4; g++) begin
        if (sOutValidA[g] && !sStop) begin
          mHead[g] = (mHead[g] + 1) % 64;
          mCnt[g]--;
        end
        if (sValid && !sInStopA[g]) begin
          mBuf[g][(mHead[g] + mCnt[g]) % 64] = sData;
          mCnt[g]++;
        end
      end
      step();
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("s%0d.fill", depthOf(g)), sFillA[g], mCnt[g]);
        chk($sformatf("s%0d.valid", depthOf(g)), int'(sOutValidA[g]), int'(mCnt[g] != 0));
        chk($sformatf("s%0d.stop", depthOf(g)), int'(sInStopA[g]), int'(mCnt[g] == depthOf(g)));
        chk($sformatf("s%0d.af", depthOf(g)), int'(sAfA[g]), int'(mCnt[g] >= depthOf(g) - 1));
        if (mCnt[g] != 0)
          chk($sformatf("s%0d.data", depthOf(g)), int'(sOutA[g]), int'(mBuf[g][mHead[g]]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
